// File: rtl/cache_fill_fsm.sv
// Two-state cache block fill controller: issues one word request per granted cycle
// and writes returned words into the data array, finishing with a tag write.
module cache_fill_fsm #(
    parameter int unsigned WORDS_PER_BLOCK = 8,
    parameter int unsigned MEM_LATENCY     = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        miss_detected,
    input  logic [15:0] miss_address,
    input  logic        mem_grant,
    input  logic        memory_data_valid,
    input  logic [15:0] memory_data,
    output logic        fsm_busy,
    output logic        mem_request,
    output logic [15:0] memory_address,
    output logic        write_data_array,
    output logic [2:0]  fill_word,
    output logic [15:0] fill_data,
    output logic        write_tag_array,
    output logic [15:0] tag_address
);

    localparam logic StIdle = 1'b0;
    localparam logic StFill = 1'b1;

    localparam logic [4:0] NumWords = 5'(WORDS_PER_BLOCK);
    localparam logic [4:0] LastWord = 5'(WORDS_PER_BLOCK - 1);

    logic        stateQ, stateD;
    logic [15:0] baseQ, baseD;
    logic [3:0]  reqCntQ, reqCntD;
    logic [3:0]  rcvCntQ, rcvCntD;
    logic        reqPending;
    logic        lastWord;

    assign reqPending = ({1'b0, reqCntQ} < NumWords);
    assign lastWord   = ({1'b0, rcvCntQ} == LastWord);
    assign fsm_busy   = (stateQ == StFill);

    always_comb begin
        stateD           = stateQ;
        baseD            = baseQ;
        reqCntD          = reqCntQ;
        rcvCntD          = rcvCntQ;
        mem_request      = 1'b0;
        memory_address   = baseQ;
        write_data_array = 1'b0;
        fill_word        = rcvCntQ[2:0];
        fill_data        = memory_data;
        write_tag_array  = 1'b0;
        tag_address      = baseQ;

        case (stateQ)
            StIdle: begin
                if (miss_detected) begin
                    baseD   = miss_address & 16'hFFF0;
                    reqCntD = 4'd0;
                    rcvCntD = 4'd0;
                    stateD  = StFill;
                end
            end
            StFill: begin
                // Requests and returns run independently so they may overlap.
                if (reqPending) begin
                    mem_request    = 1'b1;
                    memory_address = baseQ + {11'b0, reqCntQ, 1'b0};
                    if (mem_grant) begin
                        reqCntD = reqCntQ + 4'd1;
                    end
                end
                if (memory_data_valid) begin
                    write_data_array = 1'b1;
                    rcvCntD          = rcvCntQ + 4'd1;
                    if (lastWord) begin
                        write_tag_array = 1'b1;
                        stateD          = StIdle;
                    end
                end
            end
            default: stateD = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            stateQ  <= StIdle;
            baseQ   <= 16'h0000;
            reqCntQ <= 4'd0;
            rcvCntQ <= 4'd0;
        end else begin
            stateQ  <= stateD;
            baseQ   <= baseD;
            reqCntQ <= reqCntD;
            rcvCntQ <= rcvCntD;
        end
    end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Bench for cache_fill_fsm: a fixed-latency memory responder and a word-count model
// are compared against the DUT every cycle, plus directed literal checks.
module tb_cache_fill_fsm;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        miss_detected = 1'b0;
    logic [15:0] miss_address = 16'h0000;
    logic        mem_grant = 1'b0;
    logic        memory_data_valid = 1'b0;
    logic [15:0] memory_data = 16'h0000;
    logic        fsm_busy, mem_request, write_data_array, write_tag_array;
    logic [15:0] memory_address, fill_data, tag_address;
    logic [2:0]  fill_word;

    cache_fill_fsm dut (
        .clk               (clk),
        .rst               (rst),
        .miss_detected     (miss_detected),
        .miss_address      (miss_address),
        .mem_grant         (mem_grant),
        .memory_data_valid (memory_data_valid),
        .memory_data       (memory_data),
        .fsm_busy          (fsm_busy),
        .mem_request       (mem_request),
        .memory_address    (memory_address),
        .write_data_array  (write_data_array),
        .fill_word         (fill_word),
        .fill_data         (fill_data),
        .write_tag_array   (write_tag_array),
        .tag_address       (tag_address)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        int          due;
        logic [15:0] data;
    } ret_t;
    ret_t pend[$];

    // Model: block base plus how many words have been requested and received.
    bit          mBusy = 1'b0;
    logic [15:0] mBase = 16'h0000;
    int          mIssued = 0;
    int          mRcvd = 0;

    logic        obsBusy, obsReq, obsWr, obsTag;
    logic [15:0] obsAddr, obsTagAddr;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic step(input logic rstI, input logic missI, input logic [15:0] addrI,
                        input logic grantI, input logic spurI);
        logic        expReq, expWr, expTag;
        logic [15:0] expAddr;
        @(negedge clk);
        rst           = rstI;
        miss_detected = missI;
        miss_address  = addrI;
        mem_grant     = grantI;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            memory_data_valid = 1'b1;
            memory_data       = pend[0].data;
            void'(pend.pop_front());
        end else if (spurI && !mBusy && pend.size() == 0) begin
            memory_data_valid = 1'b1;
            memory_data       = 16'($urandom);
        end else begin
            memory_data_valid = 1'b0;
            memory_data       = 16'($urandom);
        end
        #1;
        obsBusy    = fsm_busy;
        obsReq     = mem_request;
        obsAddr    = memory_address;
        obsWr      = write_data_array;
        obsTag     = write_tag_array;
        obsTagAddr = tag_address;

        expReq  = mBusy && (mIssued < 8);
        expAddr = expReq ? 16'(mBase + 2 * mIssued) : mBase;
        expWr   = mBusy && memory_data_valid;
        expTag  = expWr && (mRcvd == 7);
        chk("fsm_busy", obsBusy, mBusy);
        chk("mem_request", obsReq, expReq);
        chk("memory_address", obsAddr, expAddr);
        chk("write_data_array", obsWr, expWr);
        chk("write_tag_array", obsTag, expTag);
        chk("tag_address", obsTagAddr, mBase);
        if (expWr) begin
            chk("fill_word", fill_word, 16'(mRcvd));
            chk("fill_data", fill_data, memory_data);
        end

        if (expReq && grantI) begin
            pend.push_back('{due: cyc + 4, data: expAddr ^ 16'($urandom)});
        end
        if (!rstI) begin
            mBusy = 1'b0; mBase = 16'h0000; mIssued = 0; mRcvd = 0;
        end else if (!mBusy) begin
            if (missI) begin
                mBusy = 1'b1; mBase = addrI & 16'hFFF0; mIssued = 0; mRcvd = 0;
            end
        end else begin
            if (expReq && grantI) mIssued++;
            if (expWr) begin
                mRcvd++;
                if (mRcvd == 8) mBusy = 1'b0;
            end
        end
        cyc++;
    endtask

    task automatic fillRun(input int maxCycles, input int grantPct, input string name,
                           output logic [15:0] lastReq, output logic [15:0] tagSeen,
                           output int nReq);
        bit   done = 1'b0;
        logic g;
        lastReq = 16'h0000;
        tagSeen = 16'h0000;
        nReq    = 0;
        for (int i = 0; i < maxCycles && !done; i++) begin
            g = ($urandom % 100) < grantPct;
            step(1'b1, 1'b0, 16'h0000, g, 1'b0);
            if (obsReq && g) begin
                nReq++;
                lastReq = obsAddr;
            end
            if (obsTag) begin
                tagSeen = obsTagAddr;
                done    = 1'b1;
            end
        end
        chk({name, "_done"}, 16'(done), 16'h0001);
    endtask

    task automatic drain(input int maxCycles);
        for (int i = 0; i < maxCycles && pend.size() > 0; i++) begin
            step(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
            chk("drain_no_write", obsWr, 1'b0);
        end
        chk("drain_empty", 16'(pend.size()), 16'h0000);
    endtask

    initial begin
        logic [15:0] lastReq, tagSeen;
        int          nReq, granted, gap, dup, bad, wrs, off;
        bit          found;
        logic [15:0] mask;

        repeat (2) @(posedge clk);
        // Reset state
        step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        chk("reset_busy", obsBusy, 1'b0);
        chk("reset_addr", obsAddr, 16'h0000);
        chk("reset_tagaddr", obsTagAddr, 16'h0000);

        // Basic miss with continuous grant
        step(1'b1, 1'b1, 16'h1236, 1'b1, 1'b0);
        wrs = 0;
        for (int i = 1; i <= 13; i++) begin
            step(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
            if (i <= 8) begin
                chk("basic_req", obsReq, 1'b1);
                chk("basic_addr", obsAddr, 16'(16'h1230 + 2 * (i - 1)));
            end
            if (obsWr) wrs++;
            if (i == 12) begin
                chk("basic_tag", obsTag, 1'b1);
                chk("basic_tagaddr", obsTagAddr, 16'h1230);
            end
            if (i == 13) chk("basic_busy_low", obsBusy, 1'b0);
        end
        chk("basic_writes", 16'(wrs), 16'd8);

        // Grant gap after the second request
        step(1'b1, 1'b1, 16'h123A, 1'b1, 1'b0);
        granted = 0; gap = 0; dup = 0; bad = 0; mask = 16'h0000; found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            logic g;
            g = !(granted == 2 && gap < 3);
            step(1'b1, 1'b0, 16'h0000, g, 1'b0);
            if (obsReq && g) begin
                granted++;
                off = int'(16'(obsAddr - 16'h1230)) >> 1;
                if (off > 7) bad++;
                else begin
                    if (mask[off]) dup++;
                    mask[off] = 1'b1;
                end
            end else if (obsReq) begin
                gap++;
                chk("gap_hold_addr", obsAddr, 16'h1234);
            end
            if (obsTag) found = 1'b1;
        end
        chk("gap_done", 16'(found), 16'h0001);
        chk("gap_requests", 16'(granted), 16'd8);
        chk("gap_offsets", mask, 16'h00FF);
        chk("gap_dup", 16'(dup), 16'd0);
        chk("gap_bad", 16'(bad), 16'd0);

        // Address wrap
        step(1'b1, 1'b1, 16'hFFFF, 1'b1, 1'b0);
        fillRun(80, 60, "wrap", lastReq, tagSeen, nReq);
        chk("wrap_last_req", lastReq, 16'hFFFE);
        chk("wrap_tagaddr", tagSeen, 16'hFFF0);
        chk("wrap_nreq", 16'(nReq), 16'd8);

        // Spurious valids in idle, spurious misses mid-fill
        step(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 16'h0000, 1'b1, 1'b1);
            chk("idle_no_write", obsWr, 1'b0);
        end
        step(1'b1, 1'b1, 16'h2000, 1'b1, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step(1'b1, (i % 3) == 0, 16'h4000, 1'b1, 1'b0);
            if (obsTag) begin
                found = 1'b1;
                chk("spur_tagaddr", obsTagAddr, 16'h2000);
            end
        end
        chk("spur_done", 16'(found), 16'h0001);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 16'h0000, 1'b1, 1'b1);
            chk("spur_no_refill", obsBusy, 1'b0);
        end

        // Reset after the third data return
        step(1'b1, 1'b1, 16'h3456, 1'b1, 1'b0);
        wrs = 0;
        for (int i = 0; i < 20 && wrs < 3; i++) begin
            step(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
            if (obsWr) wrs++;
        end
        chk("rst_three_writes", 16'(wrs), 16'd3);
        step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        step(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        chk("rst_busy", obsBusy, 1'b0);
        chk("rst_req", obsReq, 1'b0);
        chk("rst_addr", obsAddr, 16'h0000);
        chk("rst_tag", obsTag, 1'b0);
        chk("rst_tagaddr", obsTagAddr, 16'h0000);
        drain(20);
        step(1'b1, 1'b1, 16'h7778, 1'b1, 1'b0);
        step(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        chk("refill_first_addr", obsAddr, 16'h7770);
        fillRun(40, 100, "refill", lastReq, tagSeen, nReq);
        chk("refill_tagaddr", tagSeen, 16'h7770);

        // Back-to-back miss in the cycle fsm_busy falls
        step(1'b1, 1'b1, 16'h5550, 1'b1, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (!mBusy) begin
                step(1'b1, 1'b1, 16'h6660, 1'b1, 1'b0);
                chk("b2b_busy_low", obsBusy, 1'b0);
                found = 1'b1;
            end else begin
                step(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
            end
        end
        chk("b2b_found", 16'(found), 16'h0001);
        step(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        chk("b2b_busy", obsBusy, 1'b1);
        chk("b2b_addr", obsAddr, 16'h6660);
        fillRun(40, 100, "b2b", lastReq, tagSeen, nReq);
        chk("b2b_tagaddr", tagSeen, 16'h6660);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic rr, mm, gg, ss;
            rr = ($urandom % 300) != 0;
            mm = (mBusy || pend.size() == 0) ? (($urandom % 4) == 0) : 1'b0;
            gg = ($urandom % 10) < 7;
            ss = ($urandom % 3) == 0;
            step(rr, mm, 16'($urandom), gg, ss);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cache_fill_fsm.md
CACHE_FILL_FSM -- requirements
Module: cache_fill_fsm

Interface
REQ-001 The block SHALL have exactly one clock; reset is synchronous and active-low.
REQ-002 Parameter WORDS_PER_BLOCK, default 8, SHALL set the number of 16-bit words per cache block.
REQ-003 Parameter MEM_LATENCY, default 4, SHALL document the cycles from accepted request to data return; the FSM SHALL NOT count it, only consume memory_data_valid.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  synchronous active-low reset.
REQ-006 miss_detected  input  1  cache lookup missed this cycle.
REQ-007 miss_address  input  16  byte address of the missing access.
REQ-008 mem_grant  input  1  arbiter grants the memory port this cycle.
REQ-009 memory_data_valid  input  1  memory_data carries a returned word.
REQ-010 memory_data  input  16  returned word.
REQ-011 fsm_busy  output  1  fill in progress; upstream stalls the pipeline.
REQ-012 mem_request  output  1  request to arbiter or memory this cycle.
REQ-013 memory_address  output  16  byte address of the word requested.
REQ-014 write_data_array  output  1  write fill_data into the data array at fill_word.
REQ-015 fill_word  output  3  word offset within block for the data write.
REQ-016 fill_data  output  16  word to write, equal to memory_data.
REQ-017 write_tag_array  output  1  write the tag and valid bit for tag_address.
REQ-018 tag_address  output  16  block base address of the fill.

Function
REQ-019 The block SHALL implement exactly two states: IDLE and FILL.
REQ-020 In IDLE, miss_detected=1 SHALL latch base = miss_address & 16'hFFF0, clear req_cnt and rcv_cnt, and move to FILL on the next edge.
REQ-021 fsm_busy SHALL be 1 exactly while in FILL (registered; first high cycle is the cycle after the miss).
REQ-022 In FILL with req_cnt < WORDS_PER_BLOCK: mem_request=1 and memory_address = base + 2*req_cnt, 16-bit wrap; otherwise mem_request=0.
REQ-023 req_cnt SHALL increment only on cycles where mem_request=1 and mem_grant=1; without grant, the same address is held.
REQ-024 In FILL, memory_data_valid=1 SHALL produce, combinationally in the same cycle: write_data_array=1, fill_word = rcv_cnt, fill_data = memory_data; rcv_cnt then increments.
REQ-025 When memory_data_valid=1 and rcv_cnt = WORDS_PER_BLOCK-1: write_tag_array=1 in the same cycle, with tag_address = base; the next state SHALL be IDLE.
REQ-026 With continuous grant, a miss at cycle N SHALL yield requests in cycles N+1..N+8, data in N+5..N+12, the tag write in N+12, and fsm_busy=0 in N+13.
REQ-027 miss_detected while in FILL SHALL be ignored; base SHALL NOT change.
REQ-028 memory_data_valid while in IDLE SHALL be ignored: no array writes.
REQ-029 Requests and returns SHALL be allowed to overlap; req_cnt and rcv_cnt SHALL be independent counters, each 4 bits wide.
REQ-030 Outside the conditions above, mem_request, write_data_array and write_tag_array SHALL be 0.
REQ-031 In those cycles, fill_word and fill_data SHALL be don't-care, and memory_address and tag_address SHALL show base.

Reset
REQ-032 rst=0 at a clock edge SHALL force IDLE, req_cnt=0, rcv_cnt=0, base=0, including mid-fill.
REQ-033 After reset the block SHALL give fsm_busy=0, mem_request=0, write_data_array=0, write_tag_array=0, memory_address=0, tag_address=0.
REQ-034 Memory returns still in flight from an aborted fill and arriving after reset SHALL be ignored (state IDLE).

Verification
REQ-035 Basic miss: miss_address=16'h1236, continuous grant, data D0..D7 returned at 4-cycle latency.
- Required: addresses 1230,1232,...,123E.
- Required: 8 data writes at fill_word 0..7 with matching data.
- Required: write_tag_array with tag_address=16'h1230 in cycle N+12.
- Required: fsm_busy=0 in cycle N+13.
REQ-036 Grant gaps: mem_grant=0 for 3 cycles after the 2nd request.
- Required: memory_address stays 16'h1234 through the gap.
- Required: still 8 requests total, with no duplicate or skipped offset.
REQ-037 Wrap: miss_address=16'hFFFF -> base FFF0, last request FFFE, tag_address=16'hFFF0.
REQ-038 Spurious events: miss_detected pulses mid-fill with address 16'h4000, and memory_data_valid pulses in IDLE.
- Required: base unchanged, no extra fill, zero writes while idle.
REQ-039 Reset mid-fill: rst=0 after the 3rd data return, then late valids.
- Required: next cycle IDLE with all outputs 0, no writes from the late valids.
- Required: a new miss then fills correctly from offset 0.
REQ-040 Back-to-back misses: miss_detected=1 in the cycle fsm_busy falls -> new fill starts the next cycle with the new base.
